// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: multiplexed 3-digit common-anode 7-segment driver for a
// 12-bit BCD value. It does three jobs:
//   - scans the three digits, one digit per refresh slot;
//   - decodes BCD to segments and blanks leading zeros;
//   - updates the displayed value only at frame boundaries, so a frame
//     never shows a mix of old and new digits.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   value       BCD digits: [3:0] units, [7:4] tens, [11:8] hundreds
//   load        one-cycle strobe; captures value as pending display data
//   blank_lz    1 = blank leading zeros (sampled live)
//   seg         segments a..g on bits 0..6, polarity per SEG_ACTIVE_LOW
//   dig_sel     digit enables, bit0 = units, polarity per DIG_ACTIVE_LOW
//   frame_start one-cycle pulse when a frame begins and shadow data updates
module bcd_seg_scan #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned DIV_W          = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [2:0]  dig_sel,
  output logic        frame_start
);

  // Output levels that leave every segment and every digit dark.
  localparam logic [6:0] SegOff = {7{SEG_ACTIVE_LOW}};
  localparam logic [2:0] DigOff = {3{DIG_ACTIVE_LOW}};
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IdxUnits = 2'd0,
    IdxTens  = 2'd1,
    IdxHund  = 2'd2
  } idx_e;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  idx_e             idx_q, idx_d;
  logic [11:0]      shadow_q, shadow_d;
  logic [11:0]      pending_q, pending_d;
  logic             pend_valid_q, pend_valid_d;
  logic             frame_start_q, frame_start_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       dig_sel_q, dig_sel_d;

  logic       tick;
  logic       boundary;
  logic [3:0] hund_nib, tens_nib, unit_nib;
  logic       hund_blank, tens_blank;
  logic [3:0] cur_nib;
  logic       cur_blank;
  logic [6:0] seg_act;
  logic [2:0] dig_act;

  // Active-high segment pattern, bit0 = a .. bit6 = g.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hF:    s = 7'h00; // no-key code from the encoder shows as blank
      default: s = 7'h40; // A..E render as a dash
    endcase
    return s;
  endfunction

  // Refresh timing, digit index, pending capture and frame-aligned shadow update.
  always_comb begin
    div_cnt_d     = div_cnt_q + 1'b1;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    pend_valid_d  = pend_valid_q;
    frame_start_d = 1'b0;

    tick     = (div_cnt_q == DivLast);
    boundary = tick && (idx_q == IdxHund);

    if (tick) begin
      div_cnt_d = '0;
      case (idx_q)
        IdxUnits: idx_d = IdxTens;
        IdxTens:  idx_d = IdxHund;
        default:  idx_d = IdxUnits;
      endcase
    end

    if (load) begin
      pending_d    = value;
      pend_valid_d = 1'b1;
    end

    if (boundary) begin
      // A load on the boundary cycle bypasses pending so it lands in this frame.
      if (load) begin
        shadow_d = value;
      end else if (pend_valid_q) begin
        shadow_d = pending_q;
      end
      pend_valid_d  = 1'b0;
      frame_start_d = 1'b1;
    end
  end

  // Leading-zero blanking works on the shadow copy, so it is stable for a whole frame.
  always_comb begin
    hund_nib   = shadow_q[11:8];
    tens_nib   = shadow_q[7:4];
    unit_nib   = shadow_q[3:0];
    hund_blank = blank_lz && ((hund_nib == 4'h0) || (hund_nib == 4'hF));
    tens_blank = blank_lz && (tens_nib == 4'h0) && hund_blank;

    cur_nib   = unit_nib;
    cur_blank = 1'b0;
    dig_act   = 3'b001;
    case (idx_q)
      IdxTens: begin
        cur_nib   = tens_nib;
        cur_blank = tens_blank;
        dig_act   = 3'b010;
      end
      IdxHund: begin
        cur_nib   = hund_nib;
        cur_blank = hund_blank;
        dig_act   = 3'b100;
      end
      default: begin
        cur_nib   = unit_nib;
        cur_blank = 1'b0;
        dig_act   = 3'b001;
      end
    endcase

    seg_act   = cur_blank ? 7'h00 : bcd_to_seg(cur_nib);
    seg_d     = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    dig_sel_d = DIG_ACTIVE_LOW ? ~dig_act : dig_act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      idx_q         <= IdxUnits;
      shadow_q      <= 12'hFFF;
      pending_q     <= 12'hFFF;
      pend_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      seg_q         <= SegOff;
      dig_sel_q     <= DigOff;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      pend_valid_q  <= pend_valid_d;
      frame_start_q <= frame_start_d;
      seg_q         <= seg_d;
      dig_sel_q     <= dig_sel_d;
    end
  end

  assign seg         = seg_q;
  assign dig_sel     = dig_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with REFRESH_DIV=4: a frame is 12 cycles.
// After frame_start is seen (#1 past edge E), the outputs show
// units over E+1..E+4, tens over E+5..E+8 and hundreds over E+9..E+12.
// Slots are sampled at E+2, E+6 and E+10.
module tb_bcd_seg_scan;

  logic        clk;
  logic        rst_n;
  logic [11:0] value;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [2:0]  dig_sel;
  logic        frame_start;

  int n_pass;
  int n_total;

  bcd_seg_scan #(
    .REFRESH_DIV   (4),
    .DIV_W         (16),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_value(input logic [11:0] v);
    value = v;
    load  = 1'b1;
    tick_n(1);
    load  = 1'b0;
  endtask

  // Bounded wait for frame_start; a timeout counts as a failed comparison.
  task automatic wait_fs(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick_n(1);
      if (frame_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_total++;
    if (!seen) $display("FAIL %s: frame_start not seen within 40 cycles", name);
    else n_pass++;
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0; load = 1'b1; value = 12'h123; blank_lz = 1'b0;
    tick_n(3);
    n_total++;
    if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg);
    else n_pass++;
    n_total++;
    if (dig_sel !== 3'b111) $display("FAIL reset_dig: got %b want 111", dig_sel);
    else n_pass++;
    n_total++;
    if (frame_start !== 1'b0) $display("FAIL reset_fs: got %b want 0", frame_start);
    else n_pass++;
    rst_n = 1'b1;
    load  = 1'b0;
    cnt   = 0;
    for (int i = 0; i < 40; i++) begin
      tick_n(1);
      cnt++;
      if (frame_start === 1'b1) break;
    end
    n_total++;
    if (cnt !== 12) $display("FAIL reset_first_fs: got %0d cycles want 12", cnt);
    else n_pass++;
    tick_n(2);
    n_total++;
    if (dig_sel !== 3'b110 || seg !== 7'h7F)
      $display("FAIL reset_units: got %b/%h want 110/7f", dig_sel, seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (dig_sel !== 3'b101 || seg !== 7'h7F)
      $display("FAIL reset_tens: got %b/%h want 101/7f", dig_sel, seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (dig_sel !== 3'b011 || seg !== 7'h7F)
      $display("FAIL reset_hund: got %b/%h want 011/7f", dig_sel, seg);
    else n_pass++;
  endtask

  task automatic test_decode();
    blank_lz = 1'b0;
    load_value(12'h123);
    wait_fs("dec_fs");
    tick_n(2);
    n_total++;
    if (dig_sel !== 3'b110 || seg !== 7'h30)
      $display("FAIL dec_units: got %b/%h want 110/30", dig_sel, seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (dig_sel !== 3'b101 || seg !== 7'h24)
      $display("FAIL dec_tens: got %b/%h want 101/24", dig_sel, seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (dig_sel !== 3'b011 || seg !== 7'h79)
      $display("FAIL dec_hund: got %b/%h want 011/79", dig_sel, seg);
    else n_pass++;
  endtask

  task automatic test_blank_lz();
    blank_lz = 1'b1;
    load_value(12'h007);
    wait_fs("blz_fs");
    tick_n(2);
    n_total++;
    if (seg !== 7'h78) $display("FAIL blz_units: got %h want 78", seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (seg !== 7'h7F) $display("FAIL blz_tens: got %h want 7f", seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (seg !== 7'h7F) $display("FAIL blz_hund: got %h want 7f", seg);
    else n_pass++;
    blank_lz = 1'b0;
    wait_fs("nlz_fs");
    tick_n(6);
    n_total++;
    if (seg !== 7'h40) $display("FAIL nlz_tens: got %h want 40", seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (seg !== 7'h40) $display("FAIL nlz_hund: got %h want 40", seg);
    else n_pass++;
  endtask

  task automatic test_special();
    blank_lz = 1'b0;
    load_value(12'hFA9);
    wait_fs("spc_fs");
    tick_n(2);
    n_total++;
    if (seg !== 7'h10) $display("FAIL spc_units: got %h want 10", seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (seg !== 7'h3F) $display("FAIL spc_tens_dash: got %h want 3f", seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (seg !== 7'h7F) $display("FAIL spc_hund_blank: got %h want 7f", seg);
    else n_pass++;
  endtask

  task automatic test_mid_frame();
    load_value(12'h123);
    wait_fs("mid_fs0");
    tick_n(6);
    load_value(12'h456); // lands while idx==1
    n_total++;
    if (seg !== 7'h24) $display("FAIL mid_tens_old: got %h want 24", seg);
    else n_pass++;
    tick_n(3);
    n_total++;
    if (seg !== 7'h79) $display("FAIL mid_hund_old: got %h want 79", seg);
    else n_pass++;
    wait_fs("mid_fs1");
    tick_n(2);
    n_total++;
    if (seg !== 7'h02) $display("FAIL mid_units_new: got %h want 02", seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (seg !== 7'h12) $display("FAIL mid_tens_new: got %h want 12", seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (seg !== 7'h19) $display("FAIL mid_hund_new: got %h want 19", seg);
    else n_pass++;
  endtask

  task automatic test_boundary_load();
    wait_fs("bnd_fs0");
    tick_n(5);
    load_value(12'hAAA); // pending, overridden by the boundary load
    tick_n(5);           // now inside the boundary cycle
    value = 12'h789;
    load  = 1'b1;
    tick_n(1);
    load  = 1'b0;
    n_total++;
    if (frame_start !== 1'b1) $display("FAIL bnd_fs: got %b want 1", frame_start);
    else n_pass++;
    tick_n(2);
    n_total++;
    if (seg !== 7'h10) $display("FAIL bnd_units: got %h want 10", seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (seg !== 7'h00) $display("FAIL bnd_tens: got %h want 00", seg);
    else n_pass++;
    tick_n(4);
    n_total++;
    if (seg !== 7'h78) $display("FAIL bnd_hund: got %h want 78", seg);
    else n_pass++;
    wait_fs("bnd_fs1");
    tick_n(2);
    n_total++;
    if (seg !== 7'h10) $display("FAIL bnd_stale_pending: got %h want 10", seg);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    value = 12'h111;
    load  = 1'b1;
    tick_n(1);
    value = 12'h222;
    tick_n(1);
    load  = 1'b0;
    wait_fs("b2b_fs");
    tick_n(2);
    n_total++;
    if (seg !== 7'h24) $display("FAIL b2b_units: got %h want 24", seg);
    else n_pass++;
    tick_n(8);
    n_total++;
    if (seg !== 7'h24) $display("FAIL b2b_hund: got %h want 24", seg);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    tick_n(2);
    load_value(12'h555); // left pending, must be lost
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (seg !== 7'h7F) $display("FAIL arst_seg: got %h want 7f", seg);
    else n_pass++;
    n_total++;
    if (dig_sel !== 3'b111) $display("FAIL arst_dig: got %b want 111", dig_sel);
    else n_pass++;
    n_total++;
    if (frame_start !== 1'b0) $display("FAIL arst_fs: got %b want 0", frame_start);
    else n_pass++;
    tick_n(2);
    rst_n = 1'b1;
    wait_fs("arst_fs");
    tick_n(2);
    n_total++;
    if (dig_sel !== 3'b110 || seg !== 7'h7F)
      $display("FAIL arst_units_blank: got %b/%h want 110/7f", dig_sel, seg);
    else n_pass++;
    tick_n(8);
    n_total++;
    if (dig_sel !== 3'b011 || seg !== 7'h7F)
      $display("FAIL arst_hund_blank: got %b/%h want 011/7f", dig_sel, seg);
    else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = 12'h000;
    blank_lz = 1'b0;
    test_reset();
    test_decode();
    test_blank_lz();
    test_special();
    test_mid_frame();
    test_boundary_load();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
